// File: rtl/hangmaze_pkg.sv
// hangmaze_pkg: shared direction/key types, screen defaults and movement FSM states for the maze game.
package hangmaze_pkg;
  typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;
  typedef enum logic [1:0] {ST_IDLE, ST_SAMPLE, ST_STEP} move_state_t;
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
endpackage

// File: rtl/player_move_ctrl_if.sv
// player_move_if: keyboard/frame inputs, collision deny flags and the registered player box.
// The win output exists only when PLAYER_WIN_DETECT_EN is defined.
interface player_move_if;
  import hangmaze_pkg::*;
  logic       frame_tick;
  logic [7:0] keycode;
  logic       deny_up;
  logic       deny_down;
  logic       deny_left;
  logic       deny_right;
  logic [9:0] top;
  logic [9:0] bottom;
  logic [9:0] left;
  logic [9:0] right;
  logic       moving;
  dir_t       dir;
`ifdef PLAYER_WIN_DETECT_EN
  logic       win;
`endif
  modport master (
    input  frame_tick, keycode, deny_up, deny_down, deny_left, deny_right,
    output top, bottom, left, right, moving, dir
`ifdef PLAYER_WIN_DETECT_EN
    , output win
`endif
  );
  modport slave (
    output frame_tick, keycode, deny_up, deny_down, deny_left, deny_right,
    input  top, bottom, left, right, moving, dir
`ifdef PLAYER_WIN_DETECT_EN
    , input win
`endif
  );
endinterface

// File: rtl/move_key_decode.sv
// move_key_decode: maps a HID keycode to a WASD movement direction plus a valid flag.
module move_key_decode
  import hangmaze_pkg::*;
(
  input  logic [7:0] keycode,
  output logic       valid,
  output dir_t       dir
);
  assign valid = keycode inside {KEY_W, KEY_S, KEY_A, KEY_D};
  assign dir   = keycode == KEY_S ? DOWN : keycode == KEY_A ? LEFT : keycode == KEY_D ? RIGHT : UP;
endmodule

// File: rtl/player_move_ctrl.sv
// player_move_ctrl: frame-paced player box movement, one pixel per clock with per-pixel collision checks.
// Optional sticky goal detection and freeze is enabled by defining PLAYER_WIN_DETECT_EN.
module player_move_ctrl
  import hangmaze_pkg::*;
#(
  parameter int SIZE_X   = 16,
  parameter int SIZE_Y   = 16,
  parameter int START_X  = 8,
  parameter int START_Y  = 8,
  parameter int STEP     = 4,
  parameter int SCREEN_W = hangmaze_pkg::SCREEN_W,
  parameter int SCREEN_H = hangmaze_pkg::SCREEN_H
`ifdef PLAYER_WIN_DETECT_EN
  ,
  parameter int GOAL_X   = 600,
  parameter int GOAL_Y   = 440
`endif
) (
  input logic           Clk,
  input logic           Reset_n,
  player_move_if.master bus
);
  move_state_t state, state_nxt;
  dir_t        dir_q, dir_nxt, key_dir;
  logic [3:0]  remain, remain_nxt;
  logic [9:0]  top_q, bottom_q, left_q, right_q;
  logic [9:0]  top_nxt, bottom_nxt, left_nxt, right_nxt;
  logic        key_valid, freeze, latch, blocked, step_go;

  move_key_decode u_dec (.keycode(bus.keycode), .valid(key_valid), .dir(key_dir));

  assign latch = state == ST_SAMPLE && key_valid && !freeze;
  // Deny flags come from checkers looking at the registered box, so they already reflect every prior pixel.
  assign blocked = dir_q == UP   ? bus.deny_up    || top_q == 10'd0 :
                   dir_q == DOWN ? bus.deny_down  || bottom_q >= 10'(SCREEN_H - 1) :
                   dir_q == LEFT ? bus.deny_left  || left_q == 10'd0 :
                                   bus.deny_right || right_q >= 10'(SCREEN_W - 1);
  assign step_go = state == ST_STEP && remain != 4'd0 && !blocked;

  assign top_nxt    = step_go && dir_q == UP    ? top_q - 10'd1    : step_go && dir_q == DOWN  ? top_q + 10'd1    : top_q;
  assign bottom_nxt = step_go && dir_q == UP    ? bottom_q - 10'd1 : step_go && dir_q == DOWN  ? bottom_q + 10'd1 : bottom_q;
  assign left_nxt   = step_go && dir_q == LEFT  ? left_q - 10'd1   : step_go && dir_q == RIGHT ? left_q + 10'd1   : left_q;
  assign right_nxt  = step_go && dir_q == LEFT  ? right_q - 10'd1  : step_go && dir_q == RIGHT ? right_q + 10'd1  : right_q;

  always_comb begin
    state_nxt  = state;
    remain_nxt = remain;
    dir_nxt    = dir_q;
    case (state)
      ST_IDLE:   state_nxt = bus.frame_tick ? ST_SAMPLE : ST_IDLE;
      ST_SAMPLE: begin
        state_nxt  = latch ? ST_STEP : ST_IDLE;
        remain_nxt = latch ? 4'(STEP) : remain;
        dir_nxt    = latch ? key_dir : dir_q;
      end
      ST_STEP: begin
        state_nxt  = step_go ? ST_STEP : ST_IDLE;
        remain_nxt = step_go ? remain - 4'd1 : remain;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= ST_IDLE;
      remain   <= 4'd0;
      dir_q    <= UP;
      top_q    <= 10'(START_Y);
      bottom_q <= 10'(START_Y + SIZE_Y - 1);
      left_q   <= 10'(START_X);
      right_q  <= 10'(START_X + SIZE_X - 1);
    end else begin
      state    <= state_nxt;
      remain   <= remain_nxt;
      dir_q    <= dir_nxt;
      top_q    <= top_nxt;
      bottom_q <= bottom_nxt;
      left_q   <= left_nxt;
      right_q  <= right_nxt;
    end
  end

`ifdef PLAYER_WIN_DETECT_EN
  logic win_q, win_nxt;
  // Goal is checked on every pixel, so passing over it mid-frame counts.
  assign win_nxt = win_q || (step_go && left_nxt <= 10'(GOAL_X) && right_nxt >= 10'(GOAL_X) &&
                             top_nxt <= 10'(GOAL_Y) && bottom_nxt >= 10'(GOAL_Y));
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) win_q <= 1'b0;
    else win_q <= win_nxt;
  end
  assign freeze  = win_q;
  assign bus.win = win_q;
`else
  assign freeze = 1'b0;
`endif

  assign bus.top    = top_q;
  assign bus.bottom = bottom_q;
  assign bus.left   = left_q;
  assign bus.right  = right_q;
  assign bus.moving = state == ST_STEP;
  assign bus.dir    = dir_q;
endmodule

// File: tb/tb_player_move_ctrl.sv
// tb_player_move_ctrl: randomized frames with synthetic walls, checked against a distance-based movement model.
module tb_player_move_ctrl;
  import hangmaze_pkg::*;
  localparam int STEP = 4, SX = 16, SY = 16, X0 = 8, Y0 = 8, W = 640, H = 480, GX = 600, GY = 440;
`ifdef PLAYER_WIN_DETECT_EN
  localparam bit WIN_EN = 1'b1;
`else
  localparam bit WIN_EN = 1'b0;
`endif
  typedef struct {int top; int left; int dir; bit win;} exp_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  int   m_top = Y0, m_left = X0, m_dir = 0;
  bit   m_win = 1'b0;
  bit   wall_on [4];
  int   wall [4];
  bit   mon_prev = 1'b0;
  logic [7:0] keys [4] = '{KEY_W, KEY_S, KEY_A, KEY_D};

  player_move_if bus ();
  player_move_ctrl #(.STEP(STEP)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

  always #5 Clk = ~Clk;

  // Synthetic collision checkers: a wall line per direction, evaluated on the live box.
  always_comb begin
    bus.deny_up    = wall_on[0] && int'(bus.top) <= wall[0];
    bus.deny_down  = wall_on[1] && int'(bus.bottom) >= wall[1];
    bus.deny_left  = wall_on[2] && int'(bus.left) <= wall[2];
    bus.deny_right = wall_on[3] && int'(bus.right) >= wall[3];
  end

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int key_dir(input logic [7:0] k);
    return k == KEY_W ? 0 : k == KEY_S ? 1 : k == KEY_A ? 2 : k == KEY_D ? 3 : -1;
  endfunction

  function automatic int room(input int d);
    int scr, wl, r;
    scr = d == 0 ? m_top : d == 1 ? H - (m_top + SY) : d == 2 ? m_left : W - (m_left + SX);
    wl  = d == 0 ? m_top - wall[0] : d == 1 ? wall[1] - (m_top + SY - 1) :
          d == 2 ? m_left - wall[2] : wall[3] - (m_left + SX - 1);
    r = (wall_on[d] && wl < scr) ? wl : scr;
    if (r > STEP) r = STEP;
    if (r < 0) r = 0;
    return r;
  endfunction

  task automatic frame(input logic [7:0] key, input bit noise);
    int d, n, dx, dy, st_top, st_left, off;
    bit go;
    exp_t e;
    d = key_dir(key);
    go = d >= 0 && !m_win;
    n = go ? room(d) : 0;
    dy = d == 0 ? -1 : d == 1 ? 1 : 0;
    dx = d == 2 ? -1 : d == 3 ? 1 : 0;
    st_top = m_top;
    st_left = m_left;
    for (int i = 0; i < n; i++) begin
      m_top += dy;
      m_left += dx;
      if (WIN_EN && m_left <= GX && GX < m_left + SX && m_top <= GY && GY < m_top + SY) m_win = 1'b1;
    end
    if (go) begin
      m_dir = d;
      e = '{m_top, m_left, m_dir, m_win};
      q.push_back(e);
    end
    bus.keycode = key;
    bus.frame_tick = 1'b1;
    for (int k = 1; k <= STEP + 4; k++) begin
      @(negedge Clk);
      bus.frame_tick = noise && go && k == 2;
      if (noise && k == 2) bus.keycode = 8'($urandom);
      off = k < 2 ? 0 : (k - 2 > n ? n : k - 2);
      chk("trace_top", int'(bus.top), st_top + dy * off);
      chk("trace_left", int'(bus.left), st_left + dx * off);
      if (k == 2) chk("moving_on", int'(bus.moving), int'(go));
      if (k == n + 3) chk("moving_off", int'(bus.moving), 0);
    end
    chk("dir", int'(bus.dir), m_dir);
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (mon_prev && !bus.moving) begin
      chk("sb_nonempty", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_top", int'(bus.top), e.top);
        chk("sb_bottom", int'(bus.bottom), e.top + SY - 1);
        chk("sb_left", int'(bus.left), e.left);
        chk("sb_right", int'(bus.right), e.left + SX - 1);
        chk("sb_dir", int'(bus.dir), e.dir);
`ifdef PLAYER_WIN_DETECT_EN
        chk("sb_win", int'(bus.win), int'(e.win));
`endif
      end
    end
    mon_prev = bus.moving;
  end

  task automatic check_reset_box(input string nm);
    chk({nm, "_top"}, int'(bus.top), Y0);
    chk({nm, "_bottom"}, int'(bus.bottom), Y0 + SY - 1);
    chk({nm, "_left"}, int'(bus.left), X0);
    chk({nm, "_right"}, int'(bus.right), X0 + SX - 1);
    chk({nm, "_moving"}, int'(bus.moving), 0);
    chk({nm, "_dir"}, int'(bus.dir), 0);
`ifdef PLAYER_WIN_DETECT_EN
    chk({nm, "_win"}, int'(bus.win), 0);
`endif
  endtask

  task automatic model_reset();
    m_top = Y0;
    m_left = X0;
    m_dir = 0;
    m_win = 1'b0;
  endtask

  initial begin
    exp_t e;
    int sel;
    logic [7:0] key;
    bus.frame_tick = 1'b0;
    bus.keycode = 8'h00;
    for (int i = 0; i < 4; i++) begin
      wall_on[i] = 1'b0;
      wall[i] = 0;
    end
    #2 Reset_n = 1'b0;
    #1 check_reset_box("reset");
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;

    frame(KEY_W, 1'b0);
    chk("w_top", int'(bus.top), 4);
    chk("w_bottom", int'(bus.bottom), 19);
    wall_on[3] = 1'b1;
    wall[3] = m_left + SX - 1 + 2;
    frame(KEY_D, 1'b0);
    chk("deny_right_left", int'(bus.left), 10);
    wall_on[3] = 1'b0;
    wall_on[2] = 1'b1;
    wall[2] = 1;
    repeat (3) frame(KEY_A, 1'b0);
    chk("left_at_1", int'(bus.left), 1);
    wall_on[2] = 1'b0;
    repeat (2) frame(KEY_A, 1'b0);
    chk("left_floor", int'(bus.left), 0);
    repeat (2) frame(KEY_W, 1'b0);
    chk("top_floor", int'(bus.top), 0);
    frame(KEY_D, 1'b1);
    chk("single_frame_move", int'(bus.left), STEP);

    for (int f = 0; f < 150; f++) begin
      for (int i = 0; i < 4; i++) wall_on[i] = 1'($urandom_range(0, 1));
      wall[0] = m_top - int'($urandom_range(0, 6));
      wall[1] = m_top + SY - 1 + int'($urandom_range(0, 6));
      wall[2] = m_left - int'($urandom_range(0, 6));
      wall[3] = m_left + SX - 1 + int'($urandom_range(0, 6));
      sel = int'($urandom_range(0, 4));
      key = sel == 4 ? 8'($urandom) : keys[sel];
      frame(key, 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 4; i++) wall_on[i] = 1'b0;
    bus.keycode = m_top + SY < H - 8 ? KEY_S : KEY_W;
    bus.frame_tick = 1'b1;
    @(negedge Clk);
    bus.frame_tick = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("mid_step_moving", int'(bus.moving), 1);
    e = '{Y0, X0, 0, 1'b0};
    q.push_back(e);
    #2 Reset_n = 1'b0;
    #1 check_reset_box("async_reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    frame(KEY_D, 1'b0);
    chk("resume_left", int'(bus.left), X0 + STEP);

`ifdef PLAYER_WIN_DETECT_EN
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    repeat (148) frame(KEY_D, 1'b0);
    repeat (110) frame(KEY_S, 1'b0);
    chk("win_set", int'(bus.win), 1);
    repeat (2) frame(KEY_W, 1'b0);
    chk("win_sticky", int'(bus.win), 1);
`endif

    repeat (3) @(negedge Clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
